// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream boot loader that assembles little-endian words,
//               writes them into instruction memory and holds the CPU in
//               reset until an image with a matching XOR checksum is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        restart,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        err
);

   // Low address bits are forced to zero so every write stays word-aligned.
   localparam logic [31:0] c_base = {ADDR_BASE[31:2], 2'b00};

   typedef enum logic [2:0] {
      ST_CNT_LO = 3'd0,
      ST_CNT_HI = 3'd1,
      ST_DATA   = 3'd2,
      ST_CSUM   = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic        rx_ready_q, rx_ready_d;
   logic [15:0] count_q, count_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] word_q, word_d;
   logic [7:0]  csum_q, csum_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        cpu_rst_q, cpu_rst_d;

   logic        w_hs;
   logic [15:0] w_cnt_full;
   logic [15:0] w_word_cnt_inc;

   assign w_hs           = rx_valid & rx_ready_q;
   assign w_cnt_full     = {rx_data, count_q[7:0]};
   assign w_word_cnt_inc = word_cnt_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      word_cnt_d  = word_cnt_q;
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      // The checksum byte itself is compared, never folded in.
      if (w_hs && (state_q != ST_CSUM)) begin
         csum_d = csum_q ^ rx_data;
      end

      unique case (state_q)
         ST_CNT_LO: begin
            if (w_hs) begin
               count_d[7:0] = rx_data;
               state_d      = ST_CNT_HI;
            end
         end
         ST_CNT_HI: begin
            if (w_hs) begin
               count_d[15:8] = rx_data;
               if ({16'd0, w_cnt_full} > MAX_WORDS) begin
                  state_d = ST_ERROR;
               end else if (w_cnt_full == 16'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               word_d     = {rx_data, word_q[23:8]};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = {rx_data, word_q};
                  mem_addr_d  = c_base + {14'd0, word_cnt_q, 2'b00};
                  word_cnt_d  = w_word_cnt_inc;
                  if (w_word_cnt_inc == count_q) begin
                     state_d = ST_CSUM;
                  end
               end
            end
         end
         ST_CSUM: begin
            if (w_hs) begin
               state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (restart) begin
               state_d    = ST_CNT_LO;
               count_d    = 16'd0;
               word_cnt_d = 16'd0;
               byte_idx_d = 2'd0;
               word_d     = 24'd0;
               csum_d     = 8'd0;
               mem_addr_d = c_base;
            end
         end
         default: begin
            state_d = ST_CNT_LO;
         end
      endcase

      rx_ready_d = (state_d == ST_CNT_LO) || (state_d == ST_CNT_HI) ||
                   (state_d == ST_DATA)   || (state_d == ST_CSUM);
      done_d     = (state_d == ST_DONE);
      err_d      = (state_d == ST_ERROR);
      cpu_rst_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_CNT_LO;
         rx_ready_q  <= 1'b0;
         count_q     <= 16'd0;
         word_cnt_q  <= 16'd0;
         byte_idx_q  <= 2'd0;
         word_q      <= 24'd0;
         csum_q      <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= c_base;
         mem_wdata_q <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cpu_rst_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready_d;
         count_q     <= count_d;
         word_cnt_q  <= word_cnt_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cpu_rst_q   <= cpu_rst_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cpu_rst   = cpu_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader; expected writes are queued
//               as bytes are driven and compared on each mem_we pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        restart = 1'b0;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   int          we_cnt = 0;
   bit          gaps = 1'b0;
   logic [63:0] exp_q[$];
   logic [31:0] frame_words[$];

   imem_loader dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .restart   (restart),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every write pulse must match the oldest queued word.
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt++;
         if (exp_q.size() == 0) begin
            check("we_unexpected", exp_q.size(), 1);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("we_addr", mem_addr, e[63:32]);
            check("we_data", mem_wdata, e[31:0]);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      t = 0;
      while (!rx_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) begin
         check("rx_ready_timeout", rx_ready, 1);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // Drives count, the words in frame_words and a checksum; partial_bytes>0
   // stops after that many data bytes.
   task automatic send_frame(input logic [15:0] n, input bit bad_csum, input int partial_bytes);
      logic [7:0]  cs;
      logic [31:0] wd;
      int          sent;
      cs = 8'd0;
      sent = 0;
      send_byte(n[7:0]);  cs ^= n[7:0];
      send_byte(n[15:8]); cs ^= n[15:8];
      for (int w = 0; w < int'(n); w++) begin
         wd = frame_words[w];
         for (int k = 0; k < 4; k++) begin
            if (partial_bytes > 0 && sent == partial_bytes) return;
            if (k == 3) exp_q.push_back({32'(w * 4), wd});
            send_byte(wd[8*k +: 8]);
            cs ^= wd[8*k +: 8];
            sent++;
         end
      end
      if (partial_bytes > 0) return;
      send_byte(bad_csum ? (cs ^ 8'hA5) : cs);
   endtask

   task automatic expect_end(input bit ok, input int n);
      repeat (2) @(negedge clk);
      check("done", done, ok);
      check("err", err, !ok);
      check("cpu_rst", cpu_rst, ok);
      check("rx_ready_end", rx_ready, 0);
      check("we_count", we_cnt, n);
      check("sb_empty", exp_q.size(), 0);
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cpu_rst", cpu_rst, 0);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_mem_addr", mem_addr, 32'h0);
      we_cnt = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_rx_ready"}, rx_ready, 0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      check({tag, "_cpu_rst"}, cpu_rst, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      check_reset_values("por");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", rx_ready, 1);

      // Known two-word frame, good checksum
      frame_words = '{32'h0062E233, 32'h00B62423};
      we_cnt = 0;
      send_frame(16'd2, 1'b0, 0);
      expect_end(1'b1, 2);
      do_restart();

      // Same frame, corrupted checksum: words still written
      send_frame(16'd2, 1'b1, 0);
      expect_end(1'b0, 2);
      do_restart();

      // Oversized count rejected right after count_hi
      send_byte(8'h01);
      send_byte(8'h04);
      @(negedge clk);
      check("ovf_err", err, 1);
      check("ovf_done", done, 0);
      check("ovf_rx_ready", rx_ready, 0);
      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      check("ovf_still_err", err, 1);
      check("ovf_rx_ready2", rx_ready, 0);
      check("ovf_no_we", we_cnt, 0);
      do_restart();

      // Empty image
      send_frame(16'd0, 1'b0, 0);
      expect_end(1'b1, 0);
      do_restart();

      // Random words with random valid gaps, then gap-free
      frame_words = '{};
      for (int i = 0; i < 4; i++) frame_words.push_back($urandom);
      gaps = 1'b1;
      send_frame(16'd4, 1'b0, 0);
      expect_end(1'b1, 4);
      do_restart();
      gaps = 1'b0;
      send_frame(16'd4, 1'b0, 0);
      expect_end(1'b1, 4);
      do_restart();

      // Asynchronous reset after six data bytes of a two-word frame
      send_frame(16'd2, 1'b0, 6);
      check("partial_we", we_cnt, 1);
      #2 rst = 1'b0;
      #1 check_reset_values("mid");
      repeat (2) @(negedge clk);
      check("mid_no_we", mem_we, 0);
      rst = 1'b1;
      exp_q.delete();
      we_cnt = 0;
      frame_words = '{32'hDEADBEEF, 32'h12345678};
      send_frame(16'd2, 1'b0, 0);
      expect_end(1'b1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
